// File: rtl/irrigation_timer_ctrl_pkg.sv
// irr_pkg: shared FSM state, BCD digit type and digit limits for irrigation_timer_ctrl
package irr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [3:0] digit_t;
  localparam int SU_MAX = 9;
  localparam int ST_MAX = 5;
endpackage

// File: rtl/irrigation_timer_ctrl_digit.sv
// bcd_down_digit: one BCD down-counting digit with clamped load and borrow-out
module bcd_down_digit
  import irr_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   load,
  input  digit_t load_val,
  input  logic   dec,
  output digit_t q,
  output logic   borrow
);
  localparam digit_t TOP = digit_t'(MAX);
  assign borrow = dec && q == '0;
  always_ff @(posedge clk or posedge clear)
    if (clear) q <= '0;
    else if (load) q <= load_val > TOP ? TOP : load_val;
    else if (dec) q <= borrow ? TOP : q - 4'd1;
endmodule

// File: rtl/irrigation_timer_ctrl.sv
// irrigation_timer_ctrl: one watering cycle sequencer, BCD M:ST:SU countdown at 1 Hz.
// Define IRR_SOIL_ABORT_EN to let soil_wet abort a run and block starts.
module irrigation_timer_ctrl
  import irr_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 9
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] dur_min,
  input  logic [2:0] dur_st,
  input  logic [3:0] dur_su,
  input  logic       soil_wet,
  output logic       valve_on,
  output logic       busy,
  output logic       done,
  output logic [3:0] min_d,
  output logic [3:0] st_d,
  output logic [3:0] su_d
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic armed, tick, go, abort, kill, nz, last, su_b, st_b, unused_min_b;
`ifdef IRR_SOIL_ABORT_EN
  assign abort = stop || soil_wet;
`else
  logic unused_soil;
  assign unused_soil = soil_wet;
  assign abort = stop;
`endif
  // Clamping only lowers values above a nonzero limit, so only a zero minute limit can zero a load
  assign nz = (MAX_MIN > 0 && dur_min != '0) || dur_st != '0 || dur_su != '0;
  assign go = state == IDLE && start && !abort && armed && nz;
  assign kill = state == RUN && abort;
  assign tick = state == RUN && pre == PW'(TICK_DIV - 1);
  assign last = min_d == '0 && st_d == '0 && su_d == 4'd1;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (go ? RUN : IDLE)
            : state == RUN ? (abort ? IDLE : (tick && last) ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state    <= IDLE;
      pre      <= '0;
      armed    <= 1'b1;
      valve_on <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pre      <= (state == RUN && !tick) ? pre + 1'b1 : '0;
      armed    <= go ? 1'b0 : (state == IDLE && !start) ? 1'b1 : armed;
      valve_on <= state_n == RUN;
      busy     <= state_n == RUN;
      done     <= state_n == DONE;
    end
  bcd_down_digit #(.MAX(SU_MAX)) u_su (
    .clk(clk), .clear(clear), .load(go || kill), .load_val(kill ? '0 : dur_su),
    .dec(tick), .q(su_d), .borrow(su_b)
  );
  bcd_down_digit #(.MAX(ST_MAX)) u_st (
    .clk(clk), .clear(clear), .load(go || kill), .load_val(kill ? '0 : {1'b0, dur_st}),
    .dec(su_b), .q(st_d), .borrow(st_b)
  );
  bcd_down_digit #(.MAX(MAX_MIN)) u_min (
    .clk(clk), .clear(clear), .load(go || kill), .load_val(kill ? '0 : dur_min),
    .dec(st_b), .q(min_d), .borrow(unused_min_b)
  );
endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// tb_irrigation_timer_ctrl: scoreboard bench for irrigation_timer_ctrl with TICK_DIV=4
module tb_irrigation_timer_ctrl;
  localparam int TD = 4;
  logic clk = 1'b0, clear = 1'b0, start = 1'b0, stop = 1'b0, soil_wet = 1'b0;
  logic [3:0] dur_min = '0, dur_su = '0;
  logic [2:0] dur_st = '0;
  logic valve_on, busy, done;
  logic [3:0] min_d, st_d, su_d;
  int checks = 0, passed = 0, done_cnt = 0, d0 = 0, secs = 0;
  logic [11:0] sb_q[$];

  irrigation_timer_ctrl #(.TICK_DIV(TD), .MAX_MIN(9)) dut (
    .clk(clk), .clear(clear), .start(start), .stop(stop), .dur_min(dur_min),
    .dur_st(dur_st), .dur_su(dur_su), .soil_wet(soil_wet), .valve_on(valve_on),
    .busy(busy), .done(done), .min_d(min_d), .st_d(st_d), .su_d(su_d)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] digits(input int r);
    return {4'(r / 60), 4'((r % 60) / 10), 4'(r % 10)};
  endfunction

  task automatic pop_cmp(input string tag);
    logic [11:0] e;
    e = sb_q.size() > 0 ? sb_q.pop_front() : 12'hfff;
    check(tag, {min_d, st_d, su_d}, e);
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input int m, input int st, input int su, input bit keep);
    secs = (m > 9 ? 9 : m) * 60 + (st > 5 ? 5 : st) * 10 + (su > 9 ? 9 : su);
    for (int i = 0; i <= secs; i++) sb_q.push_back(digits(secs - i));
    dur_min = 4'(m); dur_st = 3'(st); dur_su = 4'(su);
    start = 1'b1;
    d0 = done_cnt;
    clk1();
    check("load_valve", valve_on, 1);
    check("load_busy", busy, 1);
    pop_cmp("load_digits");
    start = keep;
  endtask

  task automatic tick_cmp(input string tag);
    repeat (TD - 1) @(posedge clk);
    clk1();
    pop_cmp(tag);
  endtask

  task automatic run_rest(input int from);
    for (int i = from; i <= secs; i++) begin
      tick_cmp("tick_digits");
      check(i < secs ? "tick_valve" : "end_valve", valve_on, i < secs);
      check(i < secs ? "tick_done" : "end_done", done, i == secs);
    end
    clk1();
    check("done_width", done, 0);
    check("done_count", done_cnt - d0, 1);
    check("idle_busy", busy, 0);
    clk1();
  endtask

  initial begin
    #2 clear = 1'b1;
    clk1();
    clk1();
    check("rst_valve", valve_on, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_digits", {min_d, st_d, su_d}, 0);
    clear = 1'b0;
    clk1();
    start_cycle(0, 1, 2, 0);
    run_rest(1);
    start_cycle(1, 0, 0, 0);
    run_rest(1);
    start_cycle(0, 7, 12, 0);
    check("clamp_secs", secs, 59);
    run_rest(1);
    dur_min = 0; dur_st = 0; dur_su = 0; start = 1'b1; d0 = done_cnt;
    repeat (5) clk1();
    check("zero_busy", busy, 0);
    check("zero_valve", valve_on, 0);
    check("zero_done", done_cnt - d0, 0);
    start = 1'b0;
    clk1();
    start_cycle(0, 0, 2, 1);
    run_rest(1);
    repeat (6) clk1();
    check("held_start_busy", busy, 0);
    start = 1'b0;
    clk1();
    start_cycle(0, 0, 1, 0);
    run_rest(1);
    start_cycle(0, 3, 0, 0);
    for (int i = 0; i < 5; i++) tick_cmp("stop_tick");
    stop = 1'b1;
    clk1();
    check("stop_valve", valve_on, 0);
    check("stop_busy", busy, 0);
    check("stop_digits", {min_d, st_d, su_d}, 0);
    sb_q.delete();
    stop = 1'b0;
    repeat (8) clk1();
    check("stop_no_done", done_cnt - d0, 0);
    dur_min = 0; dur_st = 1; dur_su = 0; start = 1'b1; stop = 1'b1;
    repeat (3) clk1();
    check("start_stop_busy", busy, 0);
    check("start_stop_digits", {min_d, st_d, su_d}, 0);
    start = 1'b0; stop = 1'b0;
    clk1();
    start_cycle(0, 1, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("clear_async_valve", valve_on, 0);
    check("clear_busy", busy, 0);
    check("clear_digits", {min_d, st_d, su_d}, 0);
    clk1();
    clear = 1'b0;
    sb_q.delete();
    clk1();
    check("post_clear_busy", busy, 0);
    check("post_clear_digits", {min_d, st_d, su_d}, 0);
    start_cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick_cmp("soil_tick");
    soil_wet = 1'b1;
`ifdef IRR_SOIL_ABORT_EN
    clk1();
    check("soil_valve", valve_on, 0);
    check("soil_digits", {min_d, st_d, su_d}, 0);
    sb_q.delete();
    dur_min = 0; dur_st = 1; dur_su = 0; start = 1'b1;
    repeat (3) clk1();
    check("soil_block_busy", busy, 0);
    check("soil_no_done", done_cnt - d0, 0);
    start = 1'b0;
    soil_wet = 1'b0;
`else
    run_rest(4);
    soil_wet = 1'b0;
`endif
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
